nv_nvdla_sdp_rdma_unpack_gen: RTL and testbench
===============================================

# nv_nvdla_sdp_rdma_unpack_gen

Parametrised atom packer for the SDP read-DMA response path. It sits between the DMA read-response FIFO and the SDP RDMA egress. It accumulates variable-occupancy DMA beats (1..MASK_BIT valid atoms, LSB-contiguous mask) into output words of NUM_ATOM_OUT atoms at arbitrary atom offsets. It emits the word with a per-atom valid mask, zero-fills unfilled slots, forwards an end-of-surface marker and flags overflow.

## Interface
- AM_DW, 64, atom width in bits.
- MASK_BIT, 2, max atoms per input beat; 1..NUM_ATOM_OUT.
- NUM_ATOM_OUT, 4, atoms per output word; power of 2, 2..16.
- CW, derived: clog2(NUM_ATOM_OUT)+1, fill-counter width.

Ports:
- nvdla_core_clk  in  1  clock.
- nvdla_core_rstn  in  1  reset, asynchronous, active-low.
- inp_pvld  in  1  input beat valid.
- inp_prdy  out  1  input ready.
- inp_data  in  MASK_BIT*AM_DW+MASK_BIT  bits [MASK_BIT*AM_DW-1:0] are atoms (atom i at [i*AM_DW +: AM_DW]); top MASK_BIT bits are the atom mask.
- inp_end  in  1  last beat of the transfer; forces word close.
- out_pvld  out  1  packed word valid.
- out_prdy  in  1  downstream ready.
- out_data  out  NUM_ATOM_OUT*AM_DW  packed atoms, slot k at [k*AM_DW +: AM_DW].
- out_mask  out  NUM_ATOM_OUT  slot valid bits, LSB-contiguous.
- out_end  out  1  word closed by inp_end.
- err_ovfl  out  1  sticky overflow flag.
- err_clr  in  1  synchronous clear of err_ovfl.

## Operation
- inp_prdy = !out_pvld | out_prdy (combinational). Accept when inp_acc = inp_pvld & inp_prdy.
- size = popcount(mask), width CW. fill_nxt = fill + size, computed at CW+1 bits with no wrap.
- Placement: on inp_acc, input atom i with mask[i]=1 is written to slot fill+i. Slots not addressed keep their contents.
- close = inp_acc & (fill_nxt >= NUM_ATOM_OUT | inp_end). On close:
  - fill <= 0.
  - out_pvld <= 1.
  - out_mask <= (1<<min(fill_nxt,NUM_ATOM_OUT))-1.
  - out_end <= inp_end.
  - Otherwise, on inp_acc, fill <= fill_nxt.
- Overflow: fill_nxt > NUM_ATOM_OUT. Atoms mapped beyond slot NUM_ATOM_OUT-1 are dropped. The word closes with a full mask and err_ovfl <= 1. err_ovfl holds until err_clr. If err_clr and a new overflow occur in the same cycle, the set wins.
- Zero-fill: out_data slot k = pack_reg slot k & {AM_DW{out_mask[k]}}.
- mask==0 beat: accepted, no slot written, fill unchanged. If inp_end=1 it closes the word with the current fill. If fill==0 this gives out_mask=0 and out_end=1 (a marker-only word).
- Non-contiguous input mask is illegal. Behaviour is undefined; the bench asserts against it.
- out_pvld clears on out_prdy with no close in the same cycle.
- Back-to-back: a close coincident with out_prdy keeps out_pvld=1 and loads the new word. No bubble.

## Timing
- Reset values:
  - out_pvld=0, out_mask=0, out_end=0, err_ovfl=0, fill=0.
  - inp_prdy=1 after reset.
  - Data registers are not reset; out_data reads 0 while out_mask=0.
- Latency: out_pvld rises the cycle after the closing beat is accepted.
- Throughput: 1 input beat/cycle; 1 output word/cycle when every beat is full and MASK_BIT==NUM_ATOM_OUT.
- out_data, out_mask and out_end are stable while out_pvld & !out_prdy. Pack registers are written only on inp_acc, which cannot occur while stalled.
- Reset mid-transfer discards the partial word and any pending output.

## Test plan
- AM_DW=32, MASK_BIT=2, NUM_ATOM_OUT=4. Beats {mask=11, A1A0}, {11, A3A2} -> one word, out_data=A3A2A1A0, out_mask=1111, out_end=0, out_pvld one cycle after beat 2.
- Unaligned fill: {01,A0}, {11,B1B0}, {01,C0} -> slots C0,B1,B0,A0 (slot3..0), out_mask=1111.
- Early end: {11,A1A0} then {01,B0} with inp_end -> out_mask=0111, slot3=0, out_end=1. Next word starts at slot 0.
- Overflow: {01,A0}, {11,B1B0}, {11,C1C0} -> slots C0,B1,B0,A0 with C1 dropped, err_ovfl=1. err_clr drops it next cycle.
- Backpressure: out_prdy=0 for 5 cycles with a word pending -> inp_prdy=0 and outputs stable. Release with a closing beat already presented -> words transfer on consecutive cycles, no loss.
- Marker: fill=0, {mask=00, inp_end=1} -> out_pvld with out_mask=0000, out_end=1, out_data=0. Also assert async reset mid-word: all outputs return to reset values.

Source files
------------

// File: rtl/nv_nvdla_sdp_rdma_unpack_gen.sv
// Atom packer for the SDP read-DMA response path: gathers variable-occupancy
// DMA beats into NUM_ATOM_OUT-atom words with a per-slot valid mask.
module nv_nvdla_sdp_rdma_unpack_gen #(
  parameter int AM_DW        = 64,
  parameter int MASK_BIT     = 2,
  parameter int NUM_ATOM_OUT = 4
) (
  input  logic                              nvdla_core_clk,
  input  logic                              nvdla_core_rstn,
  input  logic                              inp_pvld,
  output logic                              inp_prdy,
  input  logic [MASK_BIT*AM_DW+MASK_BIT-1:0] inp_data,
  input  logic                              inp_end,
  output logic                              out_pvld,
  input  logic                              out_prdy,
  output logic [NUM_ATOM_OUT*AM_DW-1:0]     out_data,
  output logic [NUM_ATOM_OUT-1:0]           out_mask,
  output logic                              out_end,
  output logic                              err_ovfl,
  input  logic                              err_clr
);

  localparam int CW = $clog2(NUM_ATOM_OUT) + 1;
  localparam logic [CW:0] LP_NUM = (CW+1)'(NUM_ATOM_OUT);

  function automatic logic [CW-1:0] f_popcount(input logic [MASK_BIT-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < MASK_BIT; i++) c = c + CW'(m[i]);
    return c;
  endfunction

  // Saturates the fill count at a full word and expands it to a thermometer mask.
  function automatic logic [NUM_ATOM_OUT-1:0] f_sat_mask(input logic [CW:0] n);
    logic [NUM_ATOM_OUT-1:0] m;
    for (int k = 0; k < NUM_ATOM_OUT; k++) m[k] = (int'(n) > k);
    return m;
  endfunction

  logic [MASK_BIT-1:0][AM_DW-1:0]     w_atom;
  logic [MASK_BIT-1:0]                w_mask;
  logic [CW-1:0]                      w_size;
  logic [CW:0]                        w_fill_nxt;
  logic                               w_acc;
  logic                               w_close;
  logic                               w_ovfl;
  logic [NUM_ATOM_OUT-1:0][AM_DW-1:0] w_pack_nxt;

  logic [CW-1:0]                      r_fill;
  logic [NUM_ATOM_OUT-1:0][AM_DW-1:0] r_pack;
  logic                               r_out_pvld;
  logic [NUM_ATOM_OUT-1:0]            r_out_mask;
  logic                               r_out_end;
  logic                               r_err;

  assign w_atom     = inp_data[MASK_BIT*AM_DW-1:0];
  assign w_mask     = inp_data[MASK_BIT*AM_DW +: MASK_BIT];
  assign w_size     = f_popcount(w_mask);
  assign w_fill_nxt = {1'b0, r_fill} + {1'b0, w_size};
  assign inp_prdy   = !r_out_pvld | out_prdy;
  assign w_acc      = inp_pvld & inp_prdy;
  assign w_ovfl     = w_fill_nxt > LP_NUM;
  assign w_close    = w_acc & ((w_fill_nxt >= LP_NUM) | inp_end);

  // Atoms landing past the last slot match no k and are dropped.
  always_comb begin
    w_pack_nxt = r_pack;
    for (int k = 0; k < NUM_ATOM_OUT; k++) begin
      for (int i = 0; i < MASK_BIT; i++) begin
        if (w_mask[i] && (int'(r_fill) + i == k)) w_pack_nxt[k] = w_atom[i];
      end
    end
  end

  // Stage p0: pack register, written only on accept so it holds under stall
  always_ff @(posedge nvdla_core_clk) begin
    if (w_acc) r_pack <= w_pack_nxt;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_fill     <= '0;
      r_out_pvld <= 1'b0;
      r_out_mask <= '0;
      r_out_end  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_acc) r_fill <= w_close ? '0 : w_fill_nxt[CW-1:0];
      if (w_close) begin
        r_out_pvld <= 1'b1;
        r_out_mask <= f_sat_mask(w_fill_nxt);
        r_out_end  <= inp_end;
      end else if (out_prdy) begin
        r_out_pvld <= 1'b0;
      end
      if (w_acc && w_ovfl) r_err <= 1'b1;
      else if (err_clr)    r_err <= 1'b0;
    end
  end

  // Stage p1: output word, unfilled slots forced to zero
  always_comb begin
    out_data = '0;
    for (int k = 0; k < NUM_ATOM_OUT; k++)
      out_data[k*AM_DW +: AM_DW] = r_pack[k] & {AM_DW{r_out_mask[k]}};
  end

  assign out_pvld = r_out_pvld;
  assign out_mask = r_out_mask;
  assign out_end  = r_out_end;
  assign err_ovfl = r_err;

endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_unpack_gen.sv
// Bench for the SDP RDMA atom packer: directed literal cases plus randomized
// traffic compared every cycle against a queue-based model of the packer.
module tb_nv_nvdla_sdp_rdma_unpack_gen;

  localparam int AW = 32;
  localparam int MB = 2;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            inp_pvld, inp_prdy, inp_end;
  logic [MB*AW+MB-1:0] inp_data;
  logic            out_pvld, out_prdy, out_end, err_ovfl, err_clr;
  logic [N*AW-1:0] out_data;
  logic [N-1:0]    out_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nv_nvdla_sdp_rdma_unpack_gen #(.AM_DW(AW), .MASK_BIT(MB), .NUM_ATOM_OUT(N)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .inp_pvld       (inp_pvld),
    .inp_prdy       (inp_prdy),
    .inp_data       (inp_data),
    .inp_end        (inp_end),
    .out_pvld       (out_pvld),
    .out_prdy       (out_prdy),
    .out_data       (out_data),
    .out_mask       (out_mask),
    .out_end        (out_end),
    .err_ovfl       (err_ovfl),
    .err_clr        (err_clr)
  );

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: the open word is a queue of atoms in arrival order.
  logic [AW-1:0]  part[$];
  logic           m_pvld, m_end, m_err;
  logic [N-1:0]   m_mask;
  logic [N*AW-1:0] m_data;
  bit             m_acc, m_closed, m_ovf;
  int             m_n, m_k;
  logic [MB-1:0]  m_msk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      part.delete();
      m_pvld = 1'b0; m_end = 1'b0; m_err = 1'b0; m_mask = '0; m_data = '0;
    end else begin
      m_acc = inp_pvld && (!m_pvld || out_prdy);
      m_closed = 0;
      m_ovf = 0;
      if (m_acc) begin
        m_msk = inp_data[MB*AW +: MB];
        for (int i = 0; i < MB; i++)
          if (m_msk[i]) part.push_back(inp_data[i*AW +: AW]);
        if (inp_end || part.size() >= N) begin
          m_n = part.size();
          m_k = (m_n > N) ? N : m_n;
          m_ovf = (m_n > N);
          m_mask = N'((1 << m_k) - 1);
          m_data = '0;
          for (int s = 0; s < m_k; s++) m_data[s*AW +: AW] = part[s];
          m_end = inp_end;
          m_pvld = 1'b1;
          m_closed = 1;
          part.delete();
        end
      end
      if (!m_closed && out_prdy) m_pvld = 1'b0;
      if (m_ovf) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      cmp("inp_prdy", inp_prdy, !m_pvld || out_prdy);
      cmp("out_pvld", out_pvld, m_pvld);
      cmp("err_ovfl", err_ovfl, m_err);
      if (m_pvld) begin
        cmp("out_data", out_data, m_data);
        cmp("out_mask", out_mask, m_mask);
        cmp("out_end", out_end, m_end);
      end
      if (inp_pvld && ((inp_data[MB*AW +: MB] & (inp_data[MB*AW +: MB] + 2'd1)) != '0)) begin
        errors++;
        $display("FAIL mask_contig: got %b expected contiguous", inp_data[MB*AW +: MB]);
      end
    end
  end

  task automatic beat(input logic [1:0] m, input logic [AW-1:0] a1, input logic [AW-1:0] a0,
                      input logic e);
    int t;
    inp_data = {m, a1, a0};
    inp_end  = e;
    inp_pvld = 1'b1;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (inp_prdy) break;
      t++;
      if (t > 50) begin
        checks++; errors++;
        $display("FAIL beat_timeout: got no accept expected accept within 50 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    inp_pvld = 1'b0;
    inp_end  = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [127:0] d, input logic [3:0] m,
                     input logic e, input logic er);
    @(negedge clk);
    cmp({nm, "_pvld"}, out_pvld, 1'b1);
    cmp({nm, "_data"}, out_data, d);
    cmp({nm, "_mask"}, out_mask, m);
    cmp({nm, "_end"}, out_end, e);
    cmp({nm, "_err"}, err_ovfl, er);
    @(posedge clk); #1;
  endtask

  bit hs;
  int r;

  initial begin
    inp_pvld = 1'b0; inp_end = 1'b0; inp_data = '0;
    out_prdy = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    cmp("rst_pvld", out_pvld, 1'b0);
    cmp("rst_mask", out_mask, 4'h0);
    cmp("rst_end", out_end, 1'b0);
    cmp("rst_err", err_ovfl, 1'b0);
    cmp("rst_prdy", inp_prdy, 1'b1);
    cmp("rst_data", out_data, 128'h0);
    @(posedge clk); #1;

    beat(2'b11, 32'hA1, 32'hA0, 1'b0);
    beat(2'b11, 32'hA3, 32'hA2, 1'b0);
    lit("aligned", {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'hF, 1'b0, 1'b0);

    beat(2'b01, 32'h0, 32'hA0, 1'b0);
    beat(2'b11, 32'hB1, 32'hB0, 1'b0);
    beat(2'b01, 32'h0, 32'hC0, 1'b0);
    lit("unaligned", {32'hC0, 32'hB1, 32'hB0, 32'hA0}, 4'hF, 1'b0, 1'b0);

    beat(2'b11, 32'hA1, 32'hA0, 1'b0);
    beat(2'b01, 32'h0, 32'hB0, 1'b1);
    lit("early_end", {32'h0, 32'hB0, 32'hA1, 32'hA0}, 4'h7, 1'b1, 1'b0);
    beat(2'b11, 32'hD1, 32'hD0, 1'b0);
    beat(2'b11, 32'hD3, 32'hD2, 1'b0);
    lit("after_end", {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 4'hF, 1'b0, 1'b0);

    beat(2'b01, 32'h0, 32'hA0, 1'b0);
    beat(2'b11, 32'hB1, 32'hB0, 1'b0);
    beat(2'b11, 32'hC1, 32'hC0, 1'b0);
    lit("overflow", {32'hC0, 32'hB1, 32'hB0, 32'hA0}, 4'hF, 1'b0, 1'b1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    cmp("err_clr", err_ovfl, 1'b0);
    @(posedge clk); #1;

    out_prdy = 1'b0;
    beat(2'b11, 32'h51, 32'h50, 1'b0);
    beat(2'b11, 32'h53, 32'h52, 1'b0);
    inp_data = {2'b11, 32'hC1, 32'hC0};
    inp_end  = 1'b1;
    inp_pvld = 1'b1;
    repeat (5) begin
      @(negedge clk);
      cmp("stall_prdy", inp_prdy, 1'b0);
      cmp("stall_pvld", out_pvld, 1'b1);
      cmp("stall_data", out_data, {32'h53, 32'h52, 32'h51, 32'h50});
      cmp("stall_mask", out_mask, 4'hF);
    end
    @(posedge clk); #1;
    out_prdy = 1'b1;
    @(posedge clk); #1;
    inp_pvld = 1'b0;
    inp_end  = 1'b0;
    lit("b2b", {32'h0, 32'h0, 32'hC1, 32'hC0}, 4'h3, 1'b1, 1'b0);
    @(negedge clk);
    cmp("b2b_drain", out_pvld, 1'b0);
    @(posedge clk); #1;

    beat(2'b00, 32'h0, 32'h0, 1'b1);
    lit("marker", 128'h0, 4'h0, 1'b1, 1'b0);

    beat(2'b01, 32'h0, 32'hA0, 1'b0);
    beat(2'b11, 32'hB1, 32'hB0, 1'b0);
    beat(2'b11, 32'hC1, 32'hC0, 1'b0);
    beat(2'b11, 32'hE1, 32'hE0, 1'b0);
    #2 rstn = 1'b0;
    @(negedge clk);
    cmp("arst_pvld", out_pvld, 1'b0);
    cmp("arst_mask", out_mask, 4'h0);
    cmp("arst_end", out_end, 1'b0);
    cmp("arst_err", err_ovfl, 1'b0);
    cmp("arst_prdy", inp_prdy, 1'b1);
    cmp("arst_data", out_data, 128'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    beat(2'b11, 32'hF1, 32'hF0, 1'b0);
    beat(2'b11, 32'hF3, 32'hF2, 1'b0);
    lit("post_rst", {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 4'hF, 1'b0, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs = inp_pvld && inp_prdy;
      @(posedge clk); #1;
      if (hs || !inp_pvld) begin
        inp_pvld = ($urandom % 4) != 0;
        r = $urandom % 8;
        inp_data[MB*AW-1:0] = {$urandom, $urandom};
        inp_data[MB*AW +: MB] = (r == 0) ? 2'b00 : (r < 4) ? 2'b01 : 2'b11;
        inp_end = ($urandom % 8) == 0;
      end
      out_prdy = ($urandom % 10) < 7;
      err_clr  = ($urandom % 20) == 0;
    end
    inp_pvld = 1'b0;
    inp_end  = 1'b0;
    err_clr  = 1'b0;
    out_prdy = 1'b1;
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
